// File: rtl/four_bit_twos_complement_pkg.sv
// Shared definitions for the registered two's-complement negator:
// default width, most-negative constant and a reference negate helper.
package twos_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [DEFAULT_WIDTH-1:0] MOST_NEG = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  function automatic logic [DEFAULT_WIDTH-1:0] twos_neg(input logic [DEFAULT_WIDTH-1:0] x);
    return ~x + DEFAULT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/four_bit_twos_complement_if.sv
// Operand/result bundle for the negator; ovf exists only when
// TWOS_OVF_FLAG_EN is defined.
interface four_bit_twos_complement_if
  import twos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef TWOS_OVF_FLAG_EN
  logic             ovf;

  modport master (output a, input b, input ovf);
  modport slave  (input a, output b, output ovf);
`else
  modport master (output a, input b);
  modport slave  (input a, output b);
`endif

endinterface

// File: rtl/four_bit_twos_complement_neg_comb.sv
// Pure combinational two's-complement negation, b = (~a) + 1 mod 2^WIDTH.
module twos_neg_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  // Carry out of the MSB is dropped by the WIDTH-bit result.
  assign b = ~a + WIDTH'(1);

endmodule

// File: rtl/four_bit_twos_complement.sv
// Registered two's-complement negator, one cycle latency, sync active-high rst.
// Optional overflow flag (a == most-negative) enabled by TWOS_OVF_FLAG_EN.
module four_bit_twos_complement
  import twos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  four_bit_twos_complement_if.slave bus
);

  logic [WIDTH-1:0] neg;

  twos_neg_comb #(.WIDTH(WIDTH)) u_neg (
    .a (bus.a),
    .b (neg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.b <= '0;
    end else begin
      bus.b <= neg;
    end
  end

`ifdef TWOS_OVF_FLAG_EN
  // Most-negative input has no representable negation; flag it alongside b.
  localparam logic [WIDTH-1:0] MOST_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ovf <= 1'b0;
    end else begin
      bus.ovf <= (bus.a == MOST_NEG_W);
    end
  end
`endif

endmodule

// File: tb/tb_four_bit_twos_complement.sv
// Scoreboard bench for four_bit_twos_complement: driver queues expected
// results, monitor checks b (and ovf when TWOS_OVF_FLAG_EN) after each edge.
module tb_four_bit_twos_complement;

  typedef struct {
    logic [3:0] b;
    logic       ovf;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   errors;
  int   checks;
  bit   drive_done;

  four_bit_twos_complement_if #(.WIDTH(4)) bus ();

  four_bit_twos_complement #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic apply(input logic r, input logic [3:0] av, input logic [3:0] eb,
                       input logic eo, input string tag);
    exp_t e;
    rst   = r;
    bus.a = av;
    e.b   = eb;
    e.ovf = eo;
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_out(input exp_t e, input string phase);
    checks++;
    if (bus.b !== e.b) begin
      errors++;
      $display("FAIL %s %s: b=%b expected %b", e.tag, phase, bus.b, e.b);
    end
`ifdef TWOS_OVF_FLAG_EN
    checks++;
    if (bus.ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s %s: ovf=%b expected %b", e.tag, phase, bus.ovf, e.ovf);
    end
`endif
  endtask

  // Monitor: check just after the edge and again just before the next one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #5;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out(e, "early");
        #10;
        check_out(e, "late");
      end else if (!drive_done) begin
        errors++;
        checks++;
        $display("FAIL scoreboard: queue empty at edge, got 0 expected entry");
      end
    end
  end

  localparam logic [3:0] SWEEP_EXP [16] = '{4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9,
                                            4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

  initial begin
    errors     = 0;
    checks     = 0;
    drive_done = 1'b0;

    apply(1'b1, 4'b0101, 4'b0000, 1'b0, "reset0");
    apply(1'b1, 4'b0101, 4'b0000, 1'b0, "reset1");

    apply(1'b0, 4'b0001, 4'b1111, 1'b0, "neg_0001");
    apply(1'b0, 4'b0111, 4'b1001, 1'b0, "neg_0111");
    apply(1'b0, 4'b0011, 4'b1101, 1'b0, "neg_0011");
    apply(1'b0, 4'b0000, 4'b0000, 1'b0, "neg_zero");
    apply(1'b0, 4'b1111, 4'b0001, 1'b0, "neg_ones");
    apply(1'b0, 4'b1000, 4'b1000, 1'b1, "neg_mostneg");
    apply(1'b0, 4'b1001, 4'b0111, 1'b0, "neg_1001");

    for (int i = 0; i < 16; i++) begin
      logic [3:0] av;
      av = 4'(i);
      if (i == 6) begin
        apply(1'b1, av, 4'b0000, 1'b0, "sweep_rst");
      end
      apply(1'b0, av, SWEEP_EXP[i], (i == 8), $sformatf("sweep_%0d", i));
    end

    apply(1'b1, 4'b1000, 4'b0000, 1'b0, "reset_end");

    drive_done = 1'b1;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
